// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Desc     : Shared definitions for the ALU execute controller: ALU control
//            codes, execute FSM state type and flag bit positions.
// Revision : 1.0  initial release
// ============================================================================
package alu_pkg;

    // ALU control codes
    localparam logic [2:0] ALU_AND     = 3'd0;
    localparam logic [2:0] ALU_SUB     = 3'd1;
    localparam logic [2:0] ALU_ADD     = 3'd2;
    localparam logic [2:0] ALU_OR      = 3'd3;
    localparam logic [2:0] ALU_XOR     = 3'd4;
    localparam logic [2:0] ALU_SHIFT   = 3'd5;
    localparam logic [2:0] ALU_SHIFTSX = 3'd6;
    localparam logic [2:0] ALU_MUL     = 3'd7;

    // Bit positions inside the {C, L, F, Z, N} flag vector
    localparam int FLAG_C = 4;
    localparam int FLAG_L = 3;
    localparam int FLAG_F = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 0;

    localparam int FLAGS_W = 5;

    // Execute FSM: one operation walks IDLE -> READ -> EXEC -> WB -> IDLE
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EXEC = 2'd2,
        ST_WB   = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ============================================================================
// Module   : alu
// Desc     : Combinational ALU driven by alu_exec_ctrl. SHIFT is a logical
//            left shift and SHIFTSX an arithmetic right shift, both by the
//            low log2(WIDTH) bits of src2; MUL returns the low WIDTH bits.
// Revision : 1.0  initial release
// ============================================================================
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic [2:0]       controlCode,
    output logic [WIDTH-1:0] result
);

    localparam int SW = $clog2(WIDTH);

    // Select the operation result for the current control code
    always_comb begin
        result = '0;
        case (controlCode)
            ALU_AND:     result = src1 & src2;
            ALU_SUB:     result = src1 - src2;
            ALU_ADD:     result = src1 + src2;
            ALU_OR:      result = src1 | src2;
            ALU_XOR:     result = src1 ^ src2;
            ALU_SHIFT:   result = src1 << src2[SW-1:0];
            ALU_SHIFTSX: result = $signed(src1) >>> src2[SW-1:0];
            ALU_MUL:     result = src1 * src2;
            default:     result = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/regfile.sv
`default_nettype none
// ============================================================================
// Module   : regfile
// Desc     : NREGS x WIDTH register file, one synchronous write port, two
//            combinational operand reads and a combinational debug read.
//            Synchronous active-low clear.
// Revision : 1.0  initial release
// ============================================================================
module regfile #(
    parameter int WIDTH = 16,
    parameter int NREGS = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     we,
    input  logic [$clog2(NREGS)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(NREGS)-1:0] raddr1,
    output logic [WIDTH-1:0]         rdata1,
    input  logic [$clog2(NREGS)-1:0] raddr2,
    output logic [WIDTH-1:0]         rdata2,
    input  logic [$clog2(NREGS)-1:0] dbg_addr,
    output logic [WIDTH-1:0]         dbg_data
);

    logic [WIDTH-1:0] r_mem [NREGS];

    // Clear every entry on reset, otherwise write one entry when enabled
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata1   = r_mem[raddr1];
    assign rdata2   = r_mem[raddr2];
    assign dbg_data = r_mem[dbg_addr];

endmodule
`default_nettype wire

// File: rtl/alu_exec_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_ctrl
// Desc     : Four-cycle execute controller in front of a combinational ALU.
//            Latches one operation in IDLE, reads operands in READ, captures
//            the ALU result in EXEC and writes back / commits flags in WB.
// Config   : ALU_EXEC_FLAGS_EN - when defined, builds the {C,L,F,Z,N} flag
//            register; when undefined, flags is tied to zero.
// Revision : 1.0  initial release
// ============================================================================
module alu_exec_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NREGS = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     op_valid,
    output logic                     op_ready,
    input  logic [2:0]               op_code,
    input  logic [$clog2(NREGS)-1:0] op_rdest,
    input  logic [$clog2(NREGS)-1:0] op_rsrc,
    input  logic [WIDTH-1:0]         op_imm,
    input  logic                     op_use_imm,
    output logic [WIDTH-1:0]         alu_src1,
    output logic [WIDTH-1:0]         alu_src2,
    output logic [2:0]               alu_ctrl,
    input  logic [WIDTH-1:0]         alu_result,
    output logic                     done,
    output logic [FLAGS_W-1:0]       flags,
    input  logic [$clog2(NREGS)-1:0] dbg_addr,
    output logic [WIDTH-1:0]         dbg_data
);

    localparam int AW = $clog2(NREGS);

    state_t           r_state;
    logic [2:0]       r_op_code;
    logic [AW-1:0]    r_rdest;
    logic [AW-1:0]    r_rsrc;
    logic [WIDTH-1:0] r_imm;
    logic             r_use_imm;
    logic [WIDTH-1:0] r_result;

    logic [WIDTH-1:0] w_rdata1;
    logic [WIDTH-1:0] w_rdata2;
    logic             w_we;

    // Writeback happens on the edge that closes the WB cycle, so dbg_data
    // still shows the old register value while done is high.
    assign w_we = (r_state == ST_WB);

    regfile #(
        .WIDTH (WIDTH),
        .NREGS (NREGS)
    ) u_regfile (
        .clk      (clk),
        .reset_n  (reset_n),
        .we       (w_we),
        .waddr    (r_rdest),
        .wdata    (r_result),
        .raddr1   (r_rdest),
        .rdata1   (w_rdata1),
        .raddr2   (r_rsrc),
        .rdata2   (w_rdata2),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    // Execute sequencer with registered handshake, operand and done outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            op_ready  <= 1'b1;
            done      <= 1'b0;
            alu_src1  <= '0;
            alu_src2  <= '0;
            alu_ctrl  <= '0;
            r_op_code <= '0;
            r_rdest   <= '0;
            r_rsrc    <= '0;
            r_imm     <= '0;
            r_use_imm <= 1'b0;
            r_result  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (op_valid) begin
                        r_op_code <= op_code;
                        r_rdest   <= op_rdest;
                        r_rsrc    <= op_rsrc;
                        r_imm     <= op_imm;
                        r_use_imm <= op_use_imm;
                        op_ready  <= 1'b0;
                        r_state   <= ST_READ;
                    end
                end
                ST_READ: begin
                    alu_src1 <= w_rdata1;
                    alu_src2 <= r_use_imm ? r_imm : w_rdata2;
                    alu_ctrl <= r_op_code;
                    r_state  <= ST_EXEC;
                end
                ST_EXEC: begin
                    r_result <= alu_result;
                    done     <= 1'b1;
                    r_state  <= ST_WB;
                end
                ST_WB: begin
                    done     <= 1'b0;
                    op_ready <= 1'b1;
                    r_state  <= ST_IDLE;
                end
                default: begin
                    op_ready <= 1'b1;
                    done     <= 1'b0;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef ALU_EXEC_FLAGS_EN
    logic [FLAGS_W-1:0] r_flags;
    logic [FLAGS_W-1:0] r_next_flags;
    logic [FLAGS_W-1:0] w_next_flags;
    logic [WIDTH:0]     w_sum;
    logic               w_lt;

    // Derive next flags from the stable operands and ALU output during EXEC
    always_comb begin
        w_next_flags         = r_flags;
        w_sum                = {1'b0, alu_src1} + {1'b0, alu_src2};
        w_lt                 = (alu_src1 < alu_src2);
        w_next_flags[FLAG_Z] = (alu_result == '0);
        w_next_flags[FLAG_N] = alu_result[WIDTH-1];
        case (alu_ctrl)
            ALU_ADD: begin
                w_next_flags[FLAG_C] = w_sum[WIDTH];
                w_next_flags[FLAG_F] = (alu_src1[WIDTH-1] == alu_src2[WIDTH-1]) &&
                                       (alu_result[WIDTH-1] != alu_src1[WIDTH-1]);
            end
            ALU_SUB: begin
                w_next_flags[FLAG_C] = w_lt;
                w_next_flags[FLAG_L] = w_lt;
                w_next_flags[FLAG_F] = (alu_src1[WIDTH-1] != alu_src2[WIDTH-1]) &&
                                       (alu_result[WIDTH-1] != alu_src1[WIDTH-1]);
            end
            default: ;
        endcase
    end

    // Stage next flags in EXEC and commit them together with writeback
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_flags      <= '0;
            r_next_flags <= '0;
        end else if (r_state == ST_EXEC) begin
            r_next_flags <= w_next_flags;
        end else if (r_state == ST_WB) begin
            r_flags <= r_next_flags;
        end
    end

    assign flags = r_flags;
`else
    assign flags = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_exec_ctrl
// Desc     : Self-checking bench for alu_exec_ctrl with the real alu attached.
//            Directed scenarios plus random operations, each compared with a
//            behavioural register-file / flag model.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_exec_ctrl;
    import alu_pkg::*;

`ifdef ALU_EXEC_FLAGS_EN
    localparam bit FLAGS_EN = 1'b1;
`else
    localparam bit FLAGS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic [2:0]  op_code = '0;
    logic [3:0]  op_rdest = '0;
    logic [3:0]  op_rsrc = '0;
    logic [15:0] op_imm = '0;
    logic        op_use_imm = 1'b0;
    logic [15:0] alu_src1, alu_src2, alu_result;
    logic [2:0]  alu_ctrl;
    logic        done;
    logic [4:0]  flags;
    logic [3:0]  dbg_addr = '0;
    logic [15:0] dbg_data;

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] m_regs [16];
    logic [4:0]  m_flags;

    alu_exec_ctrl #(.WIDTH(16), .NREGS(16)) dut (
        .clk(clk), .reset_n(reset_n), .op_valid(op_valid), .op_ready(op_ready),
        .op_code(op_code), .op_rdest(op_rdest), .op_rsrc(op_rsrc), .op_imm(op_imm),
        .op_use_imm(op_use_imm), .alu_src1(alu_src1), .alu_src2(alu_src2),
        .alu_ctrl(alu_ctrl), .alu_result(alu_result), .done(done), .flags(flags),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    alu #(.WIDTH(16)) u_alu (
        .src1(alu_src1), .src2(alu_src2), .controlCode(alu_ctrl), .result(alu_result)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [15:0] model_alu(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        int     sh;
        longint p;
        logic [15:0] r;
        sh = int'(b[3:0]);
        case (op)
            3'd0: r = a & b;
            3'd1: r = a - b;
            3'd2: r = a + b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = a << sh;
            3'd6: r = a[15] ? ((a >> sh) | ~(16'hFFFF >> sh)) : (a >> sh);
            default: begin
                p = longint'(a) * longint'(b);
                r = p[15:0];
            end
        endcase
        return r;
    endfunction

    function automatic logic [4:0] model_flags(input logic [4:0] f, input logic [2:0] op,
                                               input logic [15:0] a, input logic [15:0] b,
                                               input logic [15:0] r);
        int ua, ub, sa, sb, s;
        logic [4:0] n;
        n  = f;
        ua = int'(a);
        ub = int'(b);
        sa = a[15] ? ua - 65536 : ua;
        sb = b[15] ? ub - 65536 : ub;
        n[FLAG_Z] = (r == 16'h0000);
        n[FLAG_N] = r[15];
        if (op == ALU_ADD) begin
            s = sa + sb;
            n[FLAG_C] = (ua + ub) > 65535;
            n[FLAG_F] = (s > 32767) || (s < -32768);
        end else if (op == ALU_SUB) begin
            s = sa - sb;
            n[FLAG_C] = ua < ub;
            n[FLAG_L] = ua < ub;
            n[FLAG_F] = (s > 32767) || (s < -32768);
        end
        return n;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = 16'h0000;
        m_flags = 5'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op and check every cycle of its life against the model
    task automatic run_op(input logic [2:0] code, input logic [3:0] rd, input logic [3:0] rs,
                          input logic [15:0] imm, input logic use_imm);
        logic [15:0] e1, e2, er, old;
        logic [4:0]  ef, efv;
        int waited;
        waited = 0;
        while (op_ready !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        vectors++;
        if (op_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL ready_wait: op_ready=%b expected 1", op_ready);
            return;
        end
        e1  = m_regs[rd];
        e2  = use_imm ? imm : m_regs[rs];
        er  = model_alu(code, e1, e2);
        ef  = model_flags(m_flags, code, e1, e2, er);
        efv = FLAGS_EN ? ef : 5'b0;
        old = m_regs[rd];
        op_code = code; op_rdest = rd; op_rsrc = rs; op_imm = imm; op_use_imm = use_imm;
        op_valid = 1'b1;
        dbg_addr = rd;
        tick();                                   // accept edge
        op_valid = 1'b0;
        op_code = 3'($urandom()); op_rdest = 4'($urandom()); op_rsrc = 4'($urandom());
        op_imm = 16'($urandom()); op_use_imm = 1'($urandom());
        vectors++;
        if ({op_ready, done} !== 2'b00) begin
            miscompares++;
            $display("FAIL read_cycle: ready,done=%b expected 00", {op_ready, done});
        end
        tick();                                   // EXEC cycle
        vectors++;
        if (alu_src1 !== e1) begin
            miscompares++;
            $display("FAIL alu_src1: got %h expected %h", alu_src1, e1);
        end
        vectors++;
        if (alu_src2 !== e2) begin
            miscompares++;
            $display("FAIL alu_src2: got %h expected %h", alu_src2, e2);
        end
        vectors++;
        if ({alu_ctrl, op_ready, done} !== {code, 2'b00}) begin
            miscompares++;
            $display("FAIL exec_cycle: ctrl,ready,done=%b expected %b", {alu_ctrl, op_ready, done}, {code, 2'b00});
        end
        tick();                                   // WB cycle
        vectors++;
        if ({done, op_ready} !== 2'b10 || dbg_data !== old) begin
            miscompares++;
            $display("FAIL wb_cycle: done,ready=%b dbg=%h expected 10 dbg=%h", {done, op_ready}, dbg_data, old);
        end
        tick();                                   // back in IDLE
        vectors++;
        if ({done, op_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL post_wb: done,ready=%b expected 01", {done, op_ready});
        end
        vectors++;
        if (dbg_data !== er) begin
            miscompares++;
            $display("FAIL result r%0d op%0d: got %h expected %h", rd, code, dbg_data, er);
        end
        vectors++;
        if (flags !== efv) begin
            miscompares++;
            $display("FAIL flags op%0d: got %b expected %b", code, flags, efv);
        end
        m_regs[rd] = er;
        m_flags    = ef;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        model_reset();
        vectors++;
        if ({op_ready, done, flags} !== 7'b1000000) begin
            miscompares++;
            $display("FAIL reset_ctrl: ready,done,flags=%b expected 1000000", {op_ready, done, flags});
        end
        vectors++;
        if ({alu_src1, alu_src2, alu_ctrl} !== 35'd0) begin
            miscompares++;
            $display("FAIL reset_alu_regs: got %h expected 0", {alu_src1, alu_src2, alu_ctrl});
        end
        for (int i = 0; i < 16; i++) begin
            dbg_addr = 4'(i);
            #1;
            vectors++;
            if (dbg_data !== 16'h0000) begin
                miscompares++;
                $display("FAIL reset_reg r%0d: got %h expected 0000", i, dbg_data);
            end
        end
    endtask

    task automatic test_add_carry();
        run_op(ALU_ADD, 4'd1, 4'd0, 16'h0005, 1'b1);
        run_op(ALU_ADD, 4'd1, 4'd0, 16'hFFFF, 1'b1);
        dbg_addr = 4'd1;
        #1;
        vectors++;
        if (dbg_data !== 16'h0004 || flags !== (FLAGS_EN ? 5'b10000 : 5'b0)) begin
            miscompares++;
            $display("FAIL add_carry: r1=%h flags=%b expected 0004 %b", dbg_data, flags, FLAGS_EN ? 5'b10000 : 5'b0);
        end
    endtask

    task automatic test_add_overflow();
        run_op(ALU_ADD, 4'd2, 4'd0, 16'h7FFF, 1'b1);
        run_op(ALU_ADD, 4'd2, 4'd0, 16'h0001, 1'b1);
        dbg_addr = 4'd2;
        #1;
        vectors++;
        if (dbg_data !== 16'h8000 || flags !== (FLAGS_EN ? 5'b00101 : 5'b0)) begin
            miscompares++;
            $display("FAIL add_overflow: r2=%h flags=%b expected 8000 %b", dbg_data, flags, FLAGS_EN ? 5'b00101 : 5'b0);
        end
    endtask

    task automatic test_sub_and();
        run_op(ALU_ADD, 4'd3, 4'd0, 16'h0003, 1'b1);
        run_op(ALU_ADD, 4'd4, 4'd0, 16'h0005, 1'b1);
        run_op(ALU_SUB, 4'd3, 4'd4, 16'h0000, 1'b0);
        dbg_addr = 4'd3;
        #1;
        vectors++;
        if (dbg_data !== 16'hFFFE || flags !== (FLAGS_EN ? 5'b11001 : 5'b0)) begin
            miscompares++;
            $display("FAIL sub: r3=%h flags=%b expected fffe %b", dbg_data, flags, FLAGS_EN ? 5'b11001 : 5'b0);
        end
        run_op(ALU_AND, 4'd3, 4'd0, 16'h0000, 1'b1);
        vectors++;
        if (flags !== (FLAGS_EN ? 5'b11010 : 5'b0)) begin
            miscompares++;
            $display("FAIL and_hold: flags=%b expected %b", flags, FLAGS_EN ? 5'b11010 : 5'b0);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            run_op(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                   16'($urandom()), 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  codes [4] = '{ALU_ADD, ALU_ADD, ALU_XOR, ALU_SUB};
        logic [3:0]  rds   [4] = '{4'd6, 4'd6, 4'd7, 4'd7};
        logic [3:0]  rss   [4] = '{4'd0, 4'd6, 4'd0, 4'd6};
        logic [15:0] imms  [4] = '{16'h0010, 16'h0000, 16'h1234, 16'h0000};
        logic        uses  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [15:0] a, b, r;
        logic        exp_ready;
        int idx, cyc, last_acc;
        idx = 0; cyc = 0; last_acc = -1;
        while (idx < 4 && cyc < 40) begin
            op_code = codes[idx]; op_rdest = rds[idx]; op_rsrc = rss[idx];
            op_imm = imms[idx]; op_use_imm = uses[idx]; op_valid = 1'b1;
            #1;
            exp_ready = (last_acc < 0) || (cyc - last_acc >= 4);
            vectors++;
            if (op_ready !== exp_ready) begin
                miscompares++;
                $display("FAIL b2b_ready cycle %0d: got %b expected %b", cyc, op_ready, exp_ready);
            end
            if (op_ready === 1'b1) begin
                a = m_regs[rds[idx]];
                b = uses[idx] ? imms[idx] : m_regs[rss[idx]];
                r = model_alu(codes[idx], a, b);
                m_flags = model_flags(m_flags, codes[idx], a, b, r);
                m_regs[rds[idx]] = r;
                last_acc = cyc;
                idx++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        op_valid = 1'b0;
        vectors++;
        if (idx != 4) begin
            miscompares++;
            $display("FAIL b2b_accepts: got %0d expected 4", idx);
        end
        for (int i = 0; i < 4; i++) tick();
        for (int i = 6; i < 8; i++) begin
            dbg_addr = 4'(i);
            #1;
            vectors++;
            if (dbg_data !== m_regs[i]) begin
                miscompares++;
                $display("FAIL b2b_reg r%0d: got %h expected %h", i, dbg_data, m_regs[i]);
            end
        end
        vectors++;
        if (flags !== (FLAGS_EN ? m_flags : 5'b0)) begin
            miscompares++;
            $display("FAIL b2b_flags: got %b expected %b", flags, FLAGS_EN ? m_flags : 5'b0);
        end
    endtask

    task automatic test_reset_mid();
        op_code = ALU_ADD; op_rdest = 4'd5; op_rsrc = 4'd0; op_imm = 16'h0009; op_use_imm = 1'b1;
        dbg_addr = 4'd5;
        op_valid = 1'b1;
        tick();                                   // accept
        op_valid = 1'b0;
        tick();                                   // EXEC
        reset_n = 1'b0;
        tick();                                   // reset sampled where WB would start
        reset_n = 1'b1;
        model_reset();
        vectors++;
        if ({done, op_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL reset_mid_ctrl: done,ready=%b expected 01", {done, op_ready});
        end
        tick();
        vectors++;
        if ({done, op_ready, flags} !== 7'b0100000 || dbg_data !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_mid_state: done,ready,flags=%b r5=%h expected 0100000 0000",
                     {done, op_ready, flags}, dbg_data);
        end
        run_op(ALU_ADD, 4'd1, 4'd0, 16'h0005, 1'b1);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_add_carry();
        test_add_overflow();
        test_sub_and();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
